// File: rtl/rv_pkg.sv
// Shared RV32 decode constants used by the ID/EX stage and the execute units.
package rv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPC_W = 7;
  localparam int unsigned REG_W = 5;

  localparam logic [OPC_W-1:0] OPCODE_R = 7'b0110011;
  localparam logic [OPC_W-1:0] OPCODE_I = 7'b0010011;
  localparam logic [OPC_W-1:0] LOAD     = 7'b0000011;
  localparam logic [OPC_W-1:0] STORE    = 7'b0100011;
  localparam logic [OPC_W-1:0] BRANCH   = 7'b1100011;
  localparam logic [OPC_W-1:0] LUI      = 7'b0110111;
  localparam logic [OPC_W-1:0] AUIPC    = 7'b0010111;
  localparam logic [OPC_W-1:0] JAL      = 7'b1101111;
  localparam logic [OPC_W-1:0] JALR     = 7'b1100111;
  localparam logic [OPC_W-1:0] NOP      = 7'b0000000;

  // Only U-type and JAL ignore rs1.
  function automatic logic uses_rs1(input logic [OPC_W-1:0] opcode);
    return !(opcode == LUI || opcode == AUIPC || opcode == JAL);
  endfunction

  // rs2 is read only by register-register, store and branch formats.
  function automatic logic uses_rs2(input logic [OPC_W-1:0] opcode);
    return (opcode == OPCODE_R || opcode == STORE || opcode == BRANCH);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass select: EX/MEM result, else MEM/WB result, else the registered value.
module fwd_mux #(
  parameter int unsigned XLEN = rv_pkg::XLEN
) (
  input  logic [4:0]      src_addr,
  input  logic [XLEN-1:0] reg_data,
  input  logic            exm_reg_write,
  input  logic [4:0]      exm_rd,
  input  logic [XLEN-1:0] exm_result,
  input  logic            mw_reg_write,
  input  logic [4:0]      mw_rd,
  input  logic [XLEN-1:0] mw_result,
  output logic [XLEN-1:0] data
);

  logic exm_hit;
  logic mw_hit;

  // x0 is hardwired zero, so a write to it must never be bypassed.
  assign exm_hit = exm_reg_write && (exm_rd != 5'd0) && (exm_rd == src_addr);
  assign mw_hit  = mw_reg_write  && (mw_rd  != 5'd0) && (mw_rd  == src_addr);

  always_comb begin
    data = reg_data;
    if (exm_hit) begin
      data = exm_result;
    end else if (mw_hit) begin
      data = mw_result;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubble insertion,
// global stall/flush handling and a saturating bubble counter.
module id_ex_operand_stage #(
  parameter int unsigned XLEN  = rv_pkg::XLEN,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [6:0]       id_opcode,
  input  logic [2:0]       id_func3,
  input  logic [6:0]       id_func7,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic [4:0]       id_rd_addr,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic             id_reg_write,
  input  logic             exm_reg_write,
  input  logic [4:0]       exm_rd,
  input  logic [XLEN-1:0]  exm_result,
  input  logic             mw_reg_write,
  input  logic [4:0]       mw_rd,
  input  logic [XLEN-1:0]  mw_result,
  output logic             hazard_stall,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [6:0]       ex_opcode,
  output logic [2:0]       ex_func3,
  output logic [6:0]       ex_func7,
  output logic [4:0]       ex_rd_addr,
  output logic             ex_reg_write,
  output logic [XLEN-1:0]  ex_imm,
  output logic [XLEN-1:0]  ex_rs1,
  output logic [XLEN-1:0]  ex_rs2,
  output logic [CNT_W-1:0] bubble_count
);

  import rv_pkg::*;

  logic [4:0]      ex_rs1_addr_q;
  logic [4:0]      ex_rs2_addr_q;
  logic [XLEN-1:0] ex_rs1_q;
  logic [XLEN-1:0] ex_rs2_q;
  logic            load_use;
  logic            id_reads_rs1;
  logic            id_reads_rs2;

  fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
    .src_addr      (ex_rs1_addr_q),
    .reg_data      (ex_rs1_q),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .mw_reg_write  (mw_reg_write),
    .mw_rd         (mw_rd),
    .mw_result     (mw_result),
    .data          (ex_rs1)
  );

  fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
    .src_addr      (ex_rs2_addr_q),
    .reg_data      (ex_rs2_q),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .mw_reg_write  (mw_reg_write),
    .mw_rd         (mw_rd),
    .mw_result     (mw_result),
    .data          (ex_rs2)
  );

  // A load in EX cannot feed the next instruction; the consumer waits one cycle.
  assign id_reads_rs1 = uses_rs1(id_opcode);
  assign id_reads_rs2 = uses_rs2(id_opcode);
  assign load_use = ex_valid && (ex_opcode == LOAD) && (ex_rd_addr != 5'd0) && id_valid &&
                    ((id_reads_rs1 && (ex_rd_addr == id_rs1_addr)) ||
                     (id_reads_rs2 && (ex_rd_addr == id_rs2_addr)));
  assign hazard_stall = load_use && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_pc         <= '0;
      ex_opcode     <= NOP;
      ex_func3      <= '0;
      ex_func7      <= '0;
      ex_rd_addr    <= '0;
      ex_reg_write  <= 1'b0;
      ex_imm        <= '0;
      ex_rs1_addr_q <= '0;
      ex_rs2_addr_q <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      bubble_count  <= '0;
    end else if (flush) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_opcode    <= NOP;
    end else if (stall) begin
      // Latch bypassed data so a producer retiring during the hold is not lost.
      ex_rs1_q <= ex_rs1;
      ex_rs2_q <= ex_rs2;
    end else if (load_use) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_opcode    <= NOP;
      if (bubble_count != '1) begin
        bubble_count <= bubble_count + CNT_W'(1);
      end
    end else begin
      ex_valid      <= id_valid;
      ex_pc         <= id_pc;
      ex_opcode     <= id_opcode;
      ex_func3      <= id_func3;
      ex_func7      <= id_func7;
      ex_rd_addr    <= id_rd_addr;
      ex_reg_write  <= id_reg_write && id_valid;
      ex_imm        <= id_imm;
      ex_rs1_addr_q <= id_rs1_addr;
      ex_rs2_addr_q <= id_rs2_addr;
      ex_rs1_q      <= id_rs1_data;
      ex_rs2_q      <= id_rs2_data;
    end
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed scenarios plus random traffic
// compared against a transaction-level model of the EX slot.
module tb_id_ex_operand_stage;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             stall, flush, id_valid, id_reg_write;
  logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [6:0]       id_opcode, id_func7;
  logic [2:0]       id_func3;
  logic [4:0]       id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic             exm_reg_write, mw_reg_write;
  logic [4:0]       exm_rd, mw_rd;
  logic [XLEN-1:0]  exm_result, mw_result;
  logic             hazard_stall, ex_valid, ex_reg_write;
  logic [XLEN-1:0]  ex_pc, ex_imm, ex_rs1, ex_rs2;
  logic [6:0]       ex_opcode, ex_func7;
  logic [2:0]       ex_func3;
  logic [4:0]       ex_rd_addr;
  logic [CNT_W-1:0] bubble_count;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_opcode(id_opcode), .id_func3(id_func3),
    .id_func7(id_func7), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rd_addr(id_rd_addr), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_reg_write(id_reg_write),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .mw_reg_write(mw_reg_write), .mw_rd(mw_rd), .mw_result(mw_result),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_opcode(ex_opcode), .ex_func3(ex_func3), .ex_func7(ex_func7),
    .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .bubble_count(bubble_count)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic        rw;
  } ex_t;

  ex_t         m;
  int unsigned m_cnt;
  int          total = 0;
  int          bad = 0;
  logic [6:0]  op_pool [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Writers in the pipeline are scanned youngest-first; first live non-x0 match supplies data.
  function automatic logic [31:0] ref_operand(input logic [4:0] a, input logic [31:0] own);
    logic        wr [2];
    logic [4:0]  rd [2];
    logic [31:0] v  [2];
    wr = '{exm_reg_write, mw_reg_write};
    rd = '{exm_rd, mw_rd};
    v  = '{exm_result, mw_result};
    for (int i = 0; i < 2; i++) begin
      if (wr[i] && a != 5'd0 && rd[i] == a) return v[i];
    end
    return own;
  endfunction

  function automatic logic ref_hazard();
    logic needs1, needs2;
    needs1 = !(id_opcode inside {7'b0110111, 7'b0010111, 7'b1101111});
    needs2 = id_opcode inside {7'b0110011, 7'b0100011, 7'b1100011};
    return !flush && m.valid && m.op == 7'b0000011 && m.rd != 5'd0 && id_valid &&
           ((needs1 && m.rd == id_rs1_addr) || (needs2 && m.rd == id_rs2_addr));
  endfunction

  task automatic check_all();
    chk("hazard_stall", 32'(hazard_stall), 32'(ref_hazard()));
    chk("ex_valid", 32'(ex_valid), 32'(m.valid));
    chk("ex_pc", ex_pc, m.pc);
    chk("ex_opcode", 32'(ex_opcode), 32'(m.op));
    chk("ex_func3", 32'(ex_func3), 32'(m.f3));
    chk("ex_func7", 32'(ex_func7), 32'(m.f7));
    chk("ex_rd_addr", 32'(ex_rd_addr), 32'(m.rd));
    chk("ex_reg_write", 32'(ex_reg_write), 32'(m.rw));
    chk("ex_imm", ex_imm, m.imm);
    chk("ex_rs1", ex_rs1, ref_operand(m.ra1, m.d1));
    chk("ex_rs2", ex_rs2, ref_operand(m.ra2, m.d2));
    chk("bubble_count", 32'(bubble_count), m_cnt);
  endtask

  // Advance the model by what the coming edge should do with the present inputs.
  task automatic update_model();
    logic [31:0] f1, f2;
    logic        lu;
    f1 = ref_operand(m.ra1, m.d1);
    f2 = ref_operand(m.ra2, m.d2);
    lu = ref_hazard();
    if (flush) begin
      m.valid = 1'b0; m.rw = 1'b0; m.op = 7'd0;
    end else if (stall) begin
      m.d1 = f1; m.d2 = f2;
    end else if (lu) begin
      m.valid = 1'b0; m.rw = 1'b0; m.op = 7'd0;
      m_cnt = (m_cnt == (2**CNT_W) - 1) ? m_cnt : m_cnt + 1;
    end else begin
      m = '{valid: id_valid, pc: id_pc, op: id_opcode, f3: id_func3, f7: id_func7,
            rd: id_rd_addr, ra1: id_rs1_addr, ra2: id_rs2_addr, d1: id_rs1_data,
            d2: id_rs2_data, imm: id_imm, rw: id_reg_write && id_valid};
    end
  endtask

  task automatic tick();
    #1;
    check_all();
    update_model();
    @(negedge clk);
  endtask

  task automatic idle();
    stall = 0; flush = 0; id_valid = 0; id_reg_write = 0;
    id_pc = '0; id_opcode = '0; id_func3 = '0; id_func7 = '0;
    id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0;
    id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
    exm_reg_write = 0; exm_rd = '0; exm_result = '0;
    mw_reg_write = 0; mw_rd = '0; mw_result = '0;
  endtask

  task automatic set_id(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    id_valid = 1; id_reg_write = 1; id_pc = id_pc + 32'd4;
    id_opcode = op; id_func3 = f3; id_func7 = f7;
    id_rs1_addr = rs1; id_rs2_addr = rs2; id_rd_addr = rd;
    id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
  endtask

  task automatic drive_random();
    stall = ($urandom_range(0, 7) == 0);
    flush = ($urandom_range(0, 9) == 0);
    id_valid = ($urandom_range(0, 5) != 0);
    id_reg_write = 1'($urandom);
    id_pc = $urandom; id_opcode = op_pool[$urandom_range(0, 9)];
    id_func3 = 3'($urandom); id_func7 = 7'($urandom);
    id_rs1_addr = 5'($urandom_range(0, 3)); id_rs2_addr = 5'($urandom_range(0, 3));
    id_rd_addr = 5'($urandom_range(0, 3));
    id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    exm_reg_write = 1'($urandom); exm_rd = 5'($urandom_range(0, 3)); exm_result = $urandom;
    mw_reg_write = 1'($urandom); mw_rd = 5'($urandom_range(0, 3)); mw_result = $urandom;
  endtask

  task automatic mid_reset();
    #2;
    rst_n = 0;
    #1;
    m = '0; m_cnt = 0;
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_bubble", 32'(bubble_count), 32'd0);
    check_all();
    rst_n = 1;
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst_n = 0;
    m = '0; m_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    #1 check_all();
    rst_n = 1;
    @(negedge clk);

    // Bypass priority on rs1 of an SLL held in EX.
    set_id(7'b0110011, 3'b001, 7'd0, 5'd5, 5'd6, 5'd8);
    id_rs1_data = 32'h0000_1234;
    tick();
    idle(); stall = 1;
    exm_reg_write = 1; exm_rd = 5'd5; exm_result = 32'h0000_00F0;
    mw_reg_write = 1; mw_rd = 5'd5; mw_result = 32'h0000_0001;
    #1 chk("fwd_exm_wins", ex_rs1, 32'h0000_00F0);
    exm_reg_write = 0;
    #1 chk("fwd_mw", ex_rs1, 32'h0000_0001);
    exm_reg_write = 1; exm_rd = 5'd0; mw_reg_write = 0;
    #1 chk("fwd_x0_blocked", ex_rs1, 32'h0000_1234);
    tick();
    idle();

    // Load-use on rs1: one bubble, then the consumer enters EX.
    set_id(7'b0000011, 3'b010, 7'd0, 5'd1, 5'd0, 5'd7);
    tick();
    set_id(7'b0110011, 3'b101, 7'h20, 5'd7, 5'd2, 5'd9);
    #1 chk("lu_hazard", 32'(hazard_stall), 32'd1);
    tick();
    chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
    chk("lu_count", 32'(bubble_count), 32'd1);
    tick();
    chk("lu_sra_valid", 32'(ex_valid), 32'd1);
    chk("lu_sra_func7", 32'(ex_func7), 32'h20);

    // I-type shift does not read rs2, so a matching rs2 field is ignored.
    set_id(7'b0000011, 3'b010, 7'd0, 5'd1, 5'd0, 5'd7);
    tick();
    set_id(7'b0010011, 3'b101, 7'h20, 5'd1, 5'd7, 5'd9);
    id_imm = 32'h0000_0407;
    #1 chk("rs2_filter", 32'(hazard_stall), 32'd0);
    tick();

    // Stall retains data forwarded while the producer retires.
    set_id(7'b0110011, 3'b000, 7'd0, 5'd2, 5'd3, 5'd10);
    tick();
    idle(); stall = 1;
    mw_reg_write = 1; mw_rd = 5'd3; mw_result = 32'hDEAD_BEEF;
    tick();
    mw_reg_write = 0;
    #1 chk("stall_c2", ex_rs2, 32'hDEAD_BEEF);
    tick();
    #1 chk("stall_c3", ex_rs2, 32'hDEAD_BEEF);
    tick();
    stall = 0;
    #1 chk("stall_release", ex_rs2, 32'hDEAD_BEEF);
    tick();

    // Flush beats stall and load-use; no bubble is counted.
    set_id(7'b0000011, 3'b010, 7'd0, 5'd1, 5'd0, 5'd7);
    tick();
    set_id(7'b0110011, 3'b000, 7'd0, 5'd7, 5'd2, 5'd11);
    flush = 1; stall = 1;
    #1 chk("flush_no_hazard", 32'(hazard_stall), 32'd0);
    tick();
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_opcode", 32'(ex_opcode), 32'd0);
    chk("flush_count", 32'(bubble_count), 32'd1);

    // Asynchronous reset while EX holds a live instruction.
    idle();
    set_id(7'b0110011, 3'b000, 7'd0, 5'd1, 5'd2, 5'd3);
    tick();
    chk("pre_reset_valid", 32'(ex_valid), 32'd1);
    idle();
    mid_reset();

    // Random traffic, with periodic asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      tick();
      if (i % 700 == 350) begin
        idle();
        mid_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
